// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: WIDTH-bit operands are processed CHUNK bits per stage,
// carry registered between stages, with a valid bit per slot and a global enable stall.
module adder_pipe #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH:0]   Sum,
    output logic             out_valid
);
    localparam int          STAGES    = WIDTH / CHUNK;
    localparam int          LAST      = STAGES - 1;
    localparam int unsigned PIPE_REGS = STAGES - 1;
    localparam int unsigned REGS      = (STAGES > 1) ? STAGES - 1 : 1;

    // Per-stage view of the operation currently entering that stage
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_res   [STAGES];
    logic             st_cin   [STAGES];
    logic             st_valid [STAGES];
    logic             st_sub   [STAGES];

    logic [CHUNK:0]   slice_sum [STAGES];
    logic [WIDTH-1:0] nxt_res   [STAGES];

    // Inter-stage registers: skewed operands, partial results, carry, slot tags
    logic [WIDTH-1:0] r_a     [REGS];
    logic [WIDTH-1:0] r_b     [REGS];
    logic [WIDTH-1:0] r_res   [REGS];
    logic             r_carry [REGS];
    logic             r_valid [REGS];
    logic             r_sub   [REGS];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

        if (k == 0) begin : g_head
            // B is inverted up front and sub is the carry-in, giving A + ~B + 1
            assign st_a[k]     = A;
            assign st_b[k]     = B ^ {WIDTH{sub}};
            assign st_res[k]   = '0;
            assign st_cin[k]   = sub;
            assign st_valid[k] = in_valid;
            assign st_sub[k]   = sub;
        end else begin : g_body
            assign st_a[k]     = r_a[k-1];
            assign st_b[k]     = r_b[k-1];
            assign st_res[k]   = r_res[k-1];
            assign st_cin[k]   = r_carry[k-1];
            assign st_valid[k] = r_valid[k-1];
            assign st_sub[k]   = r_sub[k-1];
        end

        assign slice_sum[k] = {1'b0, st_a[k][k*CHUNK +: CHUNK]}
                            + {1'b0, st_b[k][k*CHUNK +: CHUNK]}
                            + {{CHUNK{1'b0}}, st_cin[k]};

        assign nxt_res[k] = (st_res[k] & ~SLICE_MASK)
                          | (WIDTH'(slice_sum[k][CHUNK-1:0]) << (k * CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REGS; i++) begin
                r_valid[i] <= 1'b0;
            end
            Sum       <= '0;
            out_valid <= 1'b0;
        end else if (enable) begin
            for (int unsigned i = 0; i < PIPE_REGS; i++) begin
                r_valid[i] <= st_valid[i];
            end
            out_valid <= st_valid[LAST];
            // Final carry is the inverse of the borrow flag when subtracting
            if (st_valid[LAST]) begin
                Sum <= {slice_sum[LAST][CHUNK] ^ st_sub[LAST], nxt_res[LAST]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enable) begin
            for (int unsigned i = 0; i < PIPE_REGS; i++) begin
                r_a[i]     <= st_a[i];
                r_b[i]     <= st_b[i];
                r_res[i]   <= nxt_res[i];
                r_carry[i] <= slice_sum[i][CHUNK];
                r_sub[i]   <= st_sub[i];
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed and random checks of adder_pipe (WIDTH=16, CHUNK=4, latency 4 enabled edges).
module tb_adder_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic        sub;
    logic [16:0] Sum;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    logic        mv [3];
    logic [16:0] ms [3];
    logic [16:0] exp_sum;
    logic        exp_ov;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .Sum       (Sum),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [16:0] s);
        check({tag, "/out_valid"}, {16'b0, out_valid}, {16'b0, ov});
        check({tag, "/Sum"}, Sum, s);
    endtask

    task automatic drive(input logic r, input logic e, input logic v, input logic s,
                         input logic [15:0] a, input logic [15:0] b);
        rst      = r;
        enable   = e;
        in_valid = v;
        sub      = s;
        A        = a;
        B        = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
        return s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    initial begin
        logic        r, e, v, s;
        logic [15:0] a, b;

        // Reset held two cycles with valid inputs present
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
        tick(); expect_out("rst_c0", 1'b0, 17'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom));
        tick(); expect_out("rst_c1", 1'b0, 17'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_out("post_rst", 1'b0, 17'h0);
        end

        // Full carry ripple through all four slices
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0001);
        tick(); expect_out("ripple_e1", 1'b0, 17'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); expect_out("ripple_e2", 1'b0, 17'h0);
        tick(); expect_out("ripple_e3", 1'b0, 17'h0);
        tick(); expect_out("ripple_e4", 1'b1, 17'h10000);
        tick(); expect_out("ripple_hold", 1'b0, 17'h10000);

        // Back-to-back subtracts, borrow and no borrow
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0003, 16'h0005);
        tick(); expect_out("sub_e1", 1'b0, 17'h10000);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0003);
        tick(); expect_out("sub_e2", 1'b0, 17'h10000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); expect_out("sub_e3", 1'b0, 17'h10000);
        tick(); expect_out("sub_borrow", 1'b1, 17'h1FFFE);
        tick(); expect_out("sub_noborrow", 1'b1, 17'h00002);
        tick(); expect_out("sub_hold", 1'b0, 17'h00002);

        // Three adds in flight, then a 2-cycle stall with junk inputs offered
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001);
        tick(); expect_out("strm_s0", 1'b0, 17'h00002);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0001);
        tick(); expect_out("strm_s1", 1'b0, 17'h00002);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        tick(); expect_out("strm_s2", 1'b0, 17'h00002);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 16'h4321);
        tick(); expect_out("strm_stall0", 1'b0, 17'h00002);
        tick(); expect_out("strm_stall1", 1'b0, 17'h00002);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        tick(); expect_out("strm_r0", 1'b1, 17'h00002);
        tick(); expect_out("strm_r1", 1'b1, 17'h00100);
        tick(); expect_out("strm_r2", 1'b1, 17'h1FFFE);
        tick(); expect_out("strm_end0", 1'b0, 17'h1FFFE);
        tick(); expect_out("strm_end1", 1'b0, 17'h1FFFE);

        // Reset while two operations are in flight, with a valid input at the reset edge
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0007, 16'h0008);
        tick(); expect_out("rmid_i0", 1'b0, 17'h1FFFE);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h000A);
        tick(); expect_out("rmid_i1", 1'b0, 17'h1FFFE);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'h5555);
        tick(); expect_out("rmid_rst", 1'b0, 17'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            tick(); expect_out("rmid_after", 1'b0, 17'h0);
        end

        // Random traffic against a behavioural model delayed by 4 enabled edges
        for (int i = 0; i < 3; i++) begin
            mv[i] = 1'b0;
            ms[i] = 17'h0;
        end
        exp_sum = 17'h0;
        exp_ov  = 1'b0;
        for (int n = 0; n < 500; n++) begin
            r = ($urandom_range(99) < 5);
            e = ($urandom_range(3) != 0);
            v = 1'($urandom_range(1));
            s = 1'($urandom_range(1));
            a = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            b = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
            drive(r, e, v, s, a, b);
            tick();
            if (r) begin
                for (int i = 0; i < 3; i++) mv[i] = 1'b0;
                exp_ov  = 1'b0;
                exp_sum = 17'h0;
            end else if (e) begin
                exp_ov = mv[2];
                if (mv[2]) exp_sum = ms[2];
                mv[2] = mv[1]; ms[2] = ms[1];
                mv[1] = mv[0]; ms[1] = ms[0];
                mv[0] = v;     ms[0] = ref_op(a, b, s);
            end
            expect_out("random", exp_ov, exp_sum);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
